// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode encodings and helpers for the ALU pattern interface.
//                Shared by the ALU responder, pattern driver and checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] OP_OR  = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_NOR = 4'd12;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_OR)  || (op == OP_AND) || (op == OP_ADD) ||
               (op == OP_SUB) || (op == OP_SLT) || (op == OP_NOR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
//  Module      : alu_core
//  Description : Purely combinational ALU: (a, b, op) -> (result, z, c, v, err)
//  Ports       : a, b    operands A and B
//                op      opcode (alu_pkg encodings)
//                result  operation result
//                z/c/v   zero / carry-out / signed-overflow flags
//                err     opcode was illegal
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ERR_ZERO = 1'b1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             err
);

    // SUB and SLT share the adder: A + ~B + 1.
    logic             w_invert;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf;

    assign w_invert = (op == OP_SUB) || (op == OP_SLT);
    assign w_b_eff  = w_invert ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_invert};
    // Operands of equal sign producing a sum of the other sign.
    assign w_ovf    = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                      (w_sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        result = '0;
        c      = 1'b0;
        v      = 1'b0;
        err    = 1'b0;
        case (op)
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            OP_NOR: result = ~(a | b);
            OP_ADD, OP_SUB: begin
                result = w_sum[WIDTH-1:0];
                c      = w_sum[WIDTH];
                v      = w_ovf;
            end
            // Signed less-than: sign of the difference corrected by overflow.
            OP_SLT: result = {{(WIDTH-1){1'b0}}, w_sum[WIDTH-1] ^ w_ovf};
            default: err   = 1'b1;
        endcase
        z = err ? ERR_ZERO : ~|result;
    end

endmodule
`default_nettype wire

// File: rtl/alu_resp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : alu_resp_pipe
//  Description : Two-stage, valid/ready flow-controlled 32-bit ALU responder.
//                S1 registers operands/opcode, S2 registers result and flags.
//                Results leave in strict issue order; up to 2 ops in flight.
//  Ports       : clk, rst_n                 clock, sync active-low reset
//                in_valid/in_ready          operation handshake
//                src1, src2, ALU_control    operands and opcode
//                out_valid/out_ready        result handshake
//                result, zero, cout,
//                overflow, op_err           result and flags
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_resp_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit ERR_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic [3:0]       ALU_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             cout,
    output logic             overflow,
    output logic             op_err
);

    logic             r_s1_v;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_op;
    logic             r_s2_v;

    logic [WIDTH-1:0] w_res;
    logic             w_z;
    logic             w_c;
    logic             w_v;
    logic             w_err;
    logic             w_s2_free;

    alu_core #(
        .WIDTH    (WIDTH),
        .ERR_ZERO (ERR_ZERO)
    ) u_core (
        .a      (r_s1_a),
        .b      (r_s1_b),
        .op     (r_s1_op),
        .result (w_res),
        .z      (w_z),
        .c      (w_c),
        .v      (w_v),
        .err    (w_err)
    );

    // S2 can take a new entry when empty or being drained this cycle.
    assign w_s2_free = !r_s2_v || out_ready;
    assign in_ready  = !r_s1_v || w_s2_free;
    assign out_valid = r_s2_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_v   <= 1'b0;
            r_s1_a   <= '0;
            r_s1_b   <= '0;
            r_s1_op  <= '0;
            r_s2_v   <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            op_err   <= 1'b0;
        end else begin
            if (w_s2_free) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    result   <= w_res;
                    zero     <= w_z;
                    cout     <= w_c;
                    overflow <= w_v;
                    op_err   <= w_err;
                end
            end
            if (in_ready) begin
                r_s1_v <= in_valid;
                if (in_valid) begin
                    r_s1_a  <= src1;
                    r_s1_b  <= src2;
                    r_s1_op <= ALU_control;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_resp_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_resp_pipe
//  Description : Self-checking bench for alu_resp_pipe: reference model with
//                an expected-result queue, plus directed literal vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_resp_pipe;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        v;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALU_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic        op_err;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t expq[$];

    alu_resp_pipe #(.WIDTH(32), .ERR_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout),
        .overflow    (overflow),
        .op_err      (op_err)
    );

    always #5 clk = ~clk;

    // Reference behaviour from plain integer arithmetic.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        x;
        longint      sa;
        longint      sb;
        longint      s;
        logic [32:0] t;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        x  = '0;
        case (op)
            OP_OR:  x.r = a | b;
            OP_AND: x.r = a & b;
            OP_NOR: x.r = ~(a | b);
            OP_ADD: begin
                t   = {1'b0, a} + {1'b0, b};
                x.r = t[31:0];
                x.c = t[32];
                s   = sa + sb;
                x.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SUB: begin
                x.r = a - b;
                x.c = (a >= b);
                s   = sa - sb;
                x.v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            OP_SLT: x.r = (sa < sb) ? 32'd1 : 32'd0;
            default: x.e = 1'b1;
        endcase
        x.z = x.e ? 1'b1 : (x.r == 32'd0);
        return x;
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    // Compare process: scoreboard and hold-stability on every negedge.
    initial begin
        logic        prev_hold;
        logic [36:0] prev_out;
        exp_t        e;
        prev_hold = 1'b0;
        prev_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold)
                    check("hold_stable",
                          {out_valid, result, zero, cout, overflow, op_err},
                          {1'b1, prev_out[35:0]});
                if (out_valid && out_ready) begin
                    if (expq.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_output: got %h required none", result);
                    end else begin
                        e = expq.pop_front();
                        check("model_cmp", {result, zero, cout, overflow, op_err}, e);
                    end
                end
                if (in_valid && in_ready)
                    expq.push_back(model(ALU_control, src1, src2));
                prev_hold = out_valid && !out_ready;
                prev_out  = {1'b1, result, zero, cout, overflow, op_err};
            end
        end
    end

    // Present an op (called #1 after a posedge); returns #1 after the accept edge.
    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int k;
        src1        = a;
        src2        = b;
        ALU_control = op;
        in_valid    = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string name, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] er, input logic [2:0] zcv,
                            input logic err);
        check({name, "_model"}, model(op, a, b), {er, zcv, err});
        send(op, a, b);
        in_valid = 1'b0;
        check({name, "_lat1"}, out_valid, 0);
        @(posedge clk);
        #1;
        check({name, "_valid"}, out_valid, 1);
        check({name, "_out"}, {result, zero, cout, overflow, op_err}, {er, zcv, err});
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((expq.size() != 0 || out_valid) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain_empty", expq.size(), 0);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        src1        = '0;
        src2        = '0;
        ALU_control = '0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {in_ready, out_valid, result, zero, cout, overflow, op_err},
              {1'b1, 1'b0, 32'h0, 4'h0});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("add_ovf",   OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 3'b001, 1'b0);
        directed("sub_eq",    OP_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 3'b110, 1'b0);
        directed("sub_borrow",OP_SUB, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 3'b000, 1'b0);
        directed("slt_neg",   OP_SLT, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 3'b000, 1'b0);
        directed("slt_ovf",   OP_SLT, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 3'b000, 1'b0);
        directed("nor_zero",  OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b000, 1'b0);
        directed("and_zero",  OP_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h00000000, 3'b100, 1'b0);
        directed("illegal",   4'h3,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 3'b100, 1'b1);
        directed("after_ill", OP_ADD, 32'h00000001, 32'h00000002, 32'h00000003, 3'b000, 1'b0);

        // Full-rate stream with the consumer always ready.
        send(OP_ADD, 32'hFFFFFFFF, 32'h00000001);
        send(OP_SUB, 32'h00000003, 32'h00000007);
        send(OP_OR,  32'h00FF0000, 32'h000000FF);
        send(4'hF,   32'h1, 32'h2);
        send(OP_SLT, 32'h00000002, 32'hFFFFFFFE);
        in_valid = 1'b0;
        drain();

        // Backpressure: two accepts fill the pipe, third op waits.
        out_ready = 1'b0;
        send(OP_OR,  32'hF0F00000, 32'h0000F0F0);
        send(OP_AND, 32'hFFFF0000, 32'h0F0F0F0F);
        src1        = 32'h00000010;
        src2        = 32'h00000020;
        ALU_control = OP_ADD;
        in_valid    = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_held", {out_valid, result, zero, cout, overflow, op_err},
                  {1'b1, 32'hF0F0F0F0, 4'b0000});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset with two ops in flight discards them.
        out_ready = 1'b0;
        send(OP_ADD, 32'h00000001, 32'h00000001);
        send(OP_SUB, 32'h00000009, 32'h00000001);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("rst_flight", {out_valid, result, zero, cout, overflow, op_err},
              {1'b0, 32'h0, 4'h0});
        expq.delete();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        directed("post_reset", OP_NOR, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 3'b000, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
